// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: encodings, FSM states, ALU ops
// and the instruction classifier used in DECODE.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_MUL = 6'h18;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_t;

   typedef struct packed {
      logic    legal;
      logic    use_imm;
      alu_op_t alu_op;
   } decode_t;

   // Anything outside the supported R-type functs and addi is illegal.
   function automatic decode_t decode_instr(input logic [31:0] instr);
      decode_t d;
      d = '{legal: 1'b0, use_imm: 1'b0, alu_op: ALU_ADD};
      if (instr[31:26] == OP_ADDI) begin
         d.legal   = 1'b1;
         d.use_imm = 1'b1;
      end else if (instr[31:26] == OP_RTYPE) begin
         d.legal = 1'b1;
         case (instr[5:0])
            FN_ADD:  d.alu_op = ALU_ADD;
            FN_SUB:  d.alu_op = ALU_SUB;
            FN_AND:  d.alu_op = ALU_AND;
            FN_OR:   d.alu_op = ALU_OR;
            FN_MUL:  d.alu_op = ALU_MUL;
            default: d.legal  = 1'b0;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multi-cycle core; all results wrap modulo 2^XLEN.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      op,
   output logic [XLEN-1:0] result
);

   always_comb begin
      // NOTE: default assignment first so every path drives result and no latch is inferred.
      result = '0;
      case (alu_op_t'(op))
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_MUL: result = a * b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC/WB sequencer with req/ack instruction
// fetch, inline register file (r0 hardwired to zero) and a debug read port.
module cpu_multicycle
   import cpu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_instr_i,
   output logic [XLEN-1:0] pc_o,
   output logic            retire_o,
   output logic            halt_o,
   input  logic [4:0]      dbg_addr_i,
   output logic [XLEN-1:0] dbg_data_o
);

   localparam int         RW     = $clog2(NREG);
   localparam logic [5:0] NREG_W = 6'(NREG);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [31:0]     ir;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] imm;
   logic            use_imm;
   alu_op_t         alu_op;
   logic [RW-1:0]   wr_idx;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] regs [NREG];

   decode_t         dec;
   logic [RW-1:0]   rs_idx;
   logic [RW-1:0]   rt_idx;
   logic [RW-1:0]   rd_idx;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_y;
   logic            dbg_hit;

   assign dec    = decode_instr(ir);
   assign rs_idx = ir[21 +: RW];
   assign rt_idx = ir[16 +: RW];
   assign rd_idx = ir[11 +: RW];
   assign alu_b  = use_imm ? imm : op_b;

   cpu_alu #(.XLEN(XLEN)) u_alu (
      .a      (op_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_y)
   );

   assign imem_addr_o = pc;
   assign pc_o        = pc;

   // Index 0 and indices beyond the implemented register count read as zero.
   assign dbg_hit    = (dbg_addr_i != 5'd0) && ({1'b0, dbg_addr_i} < NREG_W);
   assign dbg_data_o = dbg_hit ? regs[dbg_addr_i[RW-1:0]] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         pc         <= PC_RESET;
         ir         <= '0;
         op_a       <= '0;
         op_b       <= '0;
         imm        <= '0;
         use_imm    <= 1'b0;
         alu_op     <= ALU_ADD;
         wr_idx     <= '0;
         result     <= '0;
         imem_req_o <= 1'b0;
         retire_o   <= 1'b0;
         halt_o     <= 1'b0;
         // NOTE: the register file is architecturally cleared on reset, so it is built from flops, not a RAM macro.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         retire_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state      <= FETCH;
                  imem_req_o <= 1'b1;
               end
            end
            FETCH: begin
               if (imem_ack_i) begin
                  ir         <= imem_instr_i;
                  imem_req_o <= 1'b0;
                  state      <= DECODE;
               end
            end
            DECODE: begin
               op_a    <= regs[rs_idx];
               op_b    <= regs[rt_idx];
               imm     <= {{(XLEN-16){ir[15]}}, ir[15:0]};
               use_imm <= dec.use_imm;
               alu_op  <= dec.alu_op;
               wr_idx  <= dec.use_imm ? rt_idx : rd_idx;
               if (dec.legal) begin
                  state <= EXEC;
               end else begin
                  state  <= HALT;
                  halt_o <= 1'b1;
               end
            end
            EXEC: begin
               result   <= alu_y;
               retire_o <= 1'b1;
               state    <= WB;
            end
            WB: begin
               if (wr_idx != '0) regs[wr_idx] <= result;
               pc <= pc + XLEN'(4);
               if (start_i) begin
                  state      <= FETCH;
                  imem_req_o <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            HALT: begin
               halt_o     <= 1'b1;
               imem_req_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: stalling instruction-memory model plus a
// retire scoreboard (expected PC and spacing pushed at launch, popped per retire).
module tb_cpu_multicycle;

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_instr_i;
   logic [31:0] pc_o;
   logic        retire_o;
   logic        halt_o;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_data_o;

   cpu_multicycle #(.XLEN(32), .NREG(32), .PC_RESET(32'h0)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_instr_i (imem_instr_i),
      .pc_o         (pc_o),
      .retire_o     (retire_o),
      .halt_o       (halt_o),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_data_o   (dbg_data_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- instruction memory model ----------------
   logic [31:0] imem [64];
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   logic        spurious  = 1'b0;
   logic [31:0] held_addr;

   always @(negedge clk) begin
      imem_ack_i   = 1'b0;
      imem_instr_i = '0;
      if (imem_req_o) begin
         if (wait_cnt == 0) held_addr = imem_addr_o;
         else check("addr_stable", imem_addr_o, held_addr);
         if (wait_cnt >= ack_delay) begin
            imem_ack_i   = 1'b1;
            imem_instr_i = imem[imem_addr_o[7:2]];
         end
         wait_cnt++;
      end else begin
         wait_cnt = 0;
      end
      if (spurious) begin
         imem_ack_i   = 1'b1;
         imem_instr_i = 32'hFC00_0000;
      end
   end

   // ---------------- retire scoreboard ----------------
   typedef struct {
      logic [31:0] pc;
      int          gap;
   } exp_t;

   exp_t sb[$];
   int   cycle       = 0;
   int   last_retire = 0;

   always @(negedge clk) begin
      exp_t e;
      cycle++;
      if (retire_o) begin
         if (sb.size() == 0) begin
            check("unexpected_retire", {32'd0, pc_o}, 64'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("retire_pc", pc_o, e.pc);
            if (e.gap != 0) check("retire_gap", cycle - last_retire, e.gap);
         end
         last_retire = cycle;
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input int rt, input int rs, input int imm_v);
      return {6'h08, 5'(rs), 5'(rt), 16'(imm_v)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000;
   endtask

   task automatic do_reset();
      rst_i    = 1'b0;
      start_i  = 1'b0;
      spurious = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b1;
   endtask

   task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
      dbg_addr_i = 5'(idx);
      #1;
      check(tag, dbg_data_o, exp);
   endtask

   // Launch from PC 0, expect n retires spaced gap cycles apart, drop start on the last.
   task automatic run_prog(input int n, input int gap);
      int seen   = 0;
      int budget = n * (gap + 4) + 20;
      for (int k = 0; k < n; k++) sb.push_back('{pc: 32'(4 * k), gap: (k == 0) ? 0 : gap});
      start_i = 1'b1;
      while (seen < n && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
         if (retire_o) seen++;
      end
      start_i = 1'b0;
      check("run_done", seen, n);
      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);
      check("idle_no_req", imem_req_o, 1'b0);
   endtask

   task automatic load_basic();
      clear_mem();
      imem[0] = enc_i(1, 0, 5);
      imem[1] = enc_i(2, 0, -3);
      imem[2] = enc_r(3, 1, 2, 6'h20);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int seen;
      rst_i      = 1'b0;
      start_i    = 1'b0;
      dbg_addr_i = '0;
      clear_mem();
      #2;
      check("rst_pc", pc_o, 32'h0);
      check("rst_req", imem_req_o, 1'b0);
      check("rst_retire", retire_o, 1'b0);
      check("rst_halt", halt_o, 1'b0);
      do_reset();

      // Basic program, ack every cycle.
      load_basic();
      run_prog(3, 4);
      check("t1_pc", pc_o, 32'd12);
      check_reg("t1_r1", 1, 32'd5);
      check_reg("t1_r2", 2, 32'hFFFF_FFFD);
      check_reg("t1_r3", 3, 32'd2);

      // Ack while not requesting must be ignored.
      spurious = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      spurious = 1'b0;
      check("spur_pc", pc_o, 32'd12);
      check("spur_req", imem_req_o, 1'b0);
      check("spur_halt", halt_o, 1'b0);

      // Same program with three wait cycles per fetch.
      do_reset();
      ack_delay = 3;
      run_prog(3, 7);
      ack_delay = 0;
      check("dly_pc", pc_o, 32'd12);
      check_reg("dly_r3", 3, 32'd2);
      check_reg("dly_r2", 2, 32'hFFFF_FFFD);

      // Writes to r0 are discarded.
      do_reset();
      clear_mem();
      imem[0] = enc_i(4, 0, 9);
      imem[1] = enc_i(0, 0, 7);
      imem[2] = enc_r(4, 0, 0, 6'h20);
      run_prog(3, 4);
      check_reg("r0_zero", 0, 32'd0);
      check_reg("r4_zero", 4, 32'd0);

      // Wraparound arithmetic and the remaining ALU ops.
      do_reset();
      clear_mem();
      imem[0]  = enc_i(6, 0, 32'h100);
      imem[1]  = enc_r(7, 6, 6, 6'h18);
      imem[2]  = enc_i(8, 0, 32'h8000);
      imem[3]  = enc_r(9, 8, 7, 6'h18);
      imem[4]  = enc_i(1, 9, -1);
      imem[5]  = enc_i(1, 1, 1);
      imem[6]  = enc_r(10, 1, 0, 6'h20);
      imem[7]  = enc_r(1, 7, 0, 6'h20);
      imem[8]  = enc_r(5, 1, 1, 6'h18);
      imem[9]  = enc_r(11, 0, 6, 6'h22);
      imem[10] = enc_r(12, 11, 7, 6'h24);
      imem[11] = enc_r(13, 6, 7, 6'h25);
      run_prog(12, 4);
      check_reg("mul_r7", 7, 32'h0001_0000);
      check_reg("mul_r9", 9, 32'h8000_0000);
      check_reg("ovf_r10", 10, 32'h8000_0000);
      check_reg("mov_r1", 1, 32'h0001_0000);
      check_reg("mul_r5", 5, 32'h0);
      check_reg("sub_r11", 11, 32'hFFFF_FF00);
      check_reg("and_r12", 12, 32'h0001_0000);
      check_reg("or_r13", 13, 32'h0001_0100);
      check("t3_halt", halt_o, 1'b0);

      // Illegal opcode at PC 8 halts.
      do_reset();
      clear_mem();
      imem[0] = enc_i(1, 0, 5);
      imem[1] = enc_i(2, 0, 6);
      imem[2] = 32'hFC00_0000;
      imem[3] = enc_i(3, 0, 1);
      sb.push_back('{pc: 32'd0, gap: 0});
      sb.push_back('{pc: 32'd4, gap: 4});
      start_i = 1'b1;
      seen = 0;
      for (int b = 0; b < 40 && seen < 2; b++) begin
         @(posedge clk);
         #1;
         if (retire_o) seen++;
      end
      check("halt_pre_retires", seen, 2);
      repeat (2) @(posedge clk);
      #1;
      check("halt_not_yet", halt_o, 1'b0);
      @(posedge clk);
      #1;
      check("halt_set", halt_o, 1'b1);
      check("halt_req", imem_req_o, 1'b0);
      check("halt_pc", pc_o, 32'd8);
      repeat (5) @(posedge clk);
      #1;
      check("halt_sticky", halt_o, 1'b1);
      check("halt_req_hold", imem_req_o, 1'b0);
      check("halt_pc_hold", pc_o, 32'd8);
      check_reg("halt_r1", 1, 32'd5);
      check_reg("halt_r2", 2, 32'd6);
      check_reg("halt_r3", 3, 32'd0);
      do_reset();
      check("halt_cleared", halt_o, 1'b0);

      // start_i dropped during EXEC: instruction retires, then idle.
      clear_mem();
      imem[0] = enc_i(1, 0, 1);
      imem[1] = enc_i(2, 0, 2);
      sb.push_back('{pc: 32'd0, gap: 0});
      start_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("drop_retire", retire_o, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("drop_req", imem_req_o, 1'b0);
      check("drop_pc", pc_o, 32'd4);
      check_reg("drop_r1", 1, 32'd1);
      check_reg("drop_r2", 2, 32'd0);

      // Reset asserted mid-FETCH.
      ack_delay = 5;
      start_i   = 1'b1;
      @(posedge clk);
      #1;
      check("mf_req", imem_req_o, 1'b1);
      check("mf_addr", imem_addr_o, 32'd4);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      #1;
      check("mf_rst_req", imem_req_o, 1'b0);
      check("mf_rst_pc", pc_o, 32'd0);
      check_reg("mf_rst_r1", 1, 32'd0);
      start_i   = 1'b0;
      ack_delay = 0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mf_idle_req", imem_req_o, 1'b0);
      check("sb_final", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multi-cycle successor to the single-cycle core: same R-type/addi subset plus mul, executed via a FETCH/DECODE/EXEC/WB state machine.
- Instruction fetch uses an external memory req/ack handshake instead of a combinational ROM.
- Owns its register file, with r0 hardwired to zero, and a debug read port.
- Sits as the core under the top-level testbench and fetches from an instruction memory model that may stall.

Parameters:
- XLEN, 32, datapath/register/PC width; immediates sign-extend to XLEN.
- NREG, 32, number of architectural registers; power of two, 2..32; register index = low clog2(NREG) bits of field.
- PC_RESET, 0, PC value after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable; level-sensitive.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  fetch address (= PC).
- imem_ack_i  in  1  fetch complete; imem_instr_i valid in the same cycle.
- imem_instr_i  in  32  instruction word.
- pc_o  out  XLEN  current PC.
- retire_o  out  1  one-cycle pulse per retired instruction.
- halt_o  out  1  sticky illegal-instruction halt.
- dbg_addr_i  in  5  debug register index.
- dbg_data_o  out  XLEN  combinational register read; index 0 and indices >= NREG return 0.

Behaviour:
- Reset (rst_i low, async): state=IDLE, PC=PC_RESET, all registers=0; imem_req_o, retire_o, halt_o=0. Reset mid-instruction aborts it: no writeback, req drops immediately.
- IDLE: if start_i=1, go to FETCH next cycle; otherwise stay.
- FETCH: imem_req_o=1, imem_addr_o=PC, both held stable until imem_ack_i sampled 1. On ack, latch imem_instr_i into IR and go to DECODE. imem_ack_i while req=0 is ignored.
- DECODE: latch A=R[rs], B=R[rt], imm=sext(IR[15:0]) to XLEN; classify.
  - op=0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, mul 0x18: legal.
  - op=0x08 (addi): legal.
  - Anything else: go to HALT.
- EXEC: result latch = ALU(A, B or imm). All arithmetic is modulo 2^XLEN; mul keeps low XLEN bits; no overflow traps.
- WB:
  - Destination = rd for R-type, rt for addi; a write to index 0 is discarded.
  - PC <= PC+4, wrapping modulo 2^XLEN.
  - retire_o=1 for this cycle only.
  - Next state: FETCH if start_i=1, else IDLE. start_i dropping mid-instruction lets the current instruction complete.
- HALT: halt_o=1, imem_req_o=0, PC frozen at the illegal instruction's address. Exit only via reset.
- Latency: minimum 4 cycles per instruction (ack in the first FETCH cycle). Each FETCH wait cycle adds one.
- Read-after-write: WB completes before the next DECODE, so no hazards exist.
- pc_o always equals the PC register.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode/funct constants (OP_RTYPE, OP_ADDI, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_MUL);
  - state enum (IDLE, FETCH, DECODE, EXEC, WB, HALT);
  - ALU-op enum.
- One sub-module, cpu_alu: combinational, XLEN-parametrised, inputs a, b, op; output result.
- Register file is inline in cpu_multicycle.

Test Plan:
- Program addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; ack every cycle -> r3=2, retire_o pulses 3 times, 4 cycles apart; pc_o=12.
- addi r0,r0,7 then add r4,r0,r0 -> dbg r0=0, r4=0; two retires.
- r1=0x7FFFFFFF, addi r1,r1,1; mul r5,r1,r1 with r1=0x10000 -> r1=0x80000000 with no trap; r5=0 (low 32 bits).
- Ack delayed 3 cycles per fetch -> imem_addr_o stable while req=1, 7 cycles per instruction, results unchanged.
- Opcode 0x3F at PC=8 -> halt_o=1 from the cycle after DECODE, req stays 0, pc_o=8, no register change. Reset clears halt_o.
- Drop start_i during EXEC -> instruction retires, state goes to IDLE, no further req. Assert rst_i low mid-FETCH -> req=0 immediately and PC=PC_RESET.
